vdot_sched: RTL and testbench



---
 rtl/vdot_sched.sv | 156 +++++++++++++++
 tb/tb_vdot_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdot_sched.sv
// Two-requester round-robin scheduler driving a shared serial FP16 MAC over
// all VLEN elements of two VRF vectors; holds the dot product and sticky overflow.
module vdot_sched #(
    parameter  int VLEN = 16,
    parameter  int DW   = 16,
    parameter  int RW   = 3,
    localparam int IW   = $clog2(VLEN)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    req,
    input  logic [RW-1:0] ra0,
    input  logic [RW-1:0] rb0,
    input  logic [RW-1:0] ra1,
    input  logic [RW-1:0] rb1,
    output logic [1:0]    grant,
    output logic [1:0]    done,
    output logic          busy,
    output logic [RW-1:0] vrf_addr_a,
    output logic [RW-1:0] vrf_addr_b,
    output logic [IW-1:0] vrf_elem,
    input  logic [DW-1:0] vrf_data_a,
    input  logic [DW-1:0] vrf_data_b,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic [DW-1:0] mac_acc,
    input  logic [DW-1:0] mac_sum,
    input  logic          mac_ovf,
    output logic [DW-1:0] result,
    output logic          V
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_owner;
    logic          r_last;
    logic [RW-1:0] r_ra;
    logic [RW-1:0] r_rb;
    logic [DW-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_result;
    logic          r_v;

    logic          w_winner;
    logic          w_abort;
    logic          w_last_elem;
    logic [1:0]    w_owner_oh;

    // On a tie the requester that was not served last wins.
    assign w_winner    = (req == 2'b11) ? ~r_last : req[1];
    assign w_abort     = (r_state == S_RUN) && !req[r_owner];
    assign w_last_elem = (r_idx == IW'(VLEN - 1));
    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req != 2'b00) w_next_state = S_RUN;
            S_RUN: begin
                if (w_abort)          w_next_state = S_IDLE;
                else if (w_last_elem) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        grant      = 2'b00;
        done       = 2'b00;
        busy       = 1'b0;
        vrf_addr_a = '0;
        vrf_addr_b = '0;
        case (r_state)
            S_RUN: begin
                grant      = w_owner_oh;
                busy       = 1'b1;
                vrf_addr_a = r_ra;
                vrf_addr_b = r_rb;
            end
            S_DONE: begin
                grant      = w_owner_oh;
                done       = w_owner_oh;
                busy       = 1'b1;
                vrf_addr_a = r_ra;
                vrf_addr_b = r_rb;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_ra     <= '0;
            r_rb     <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_owner <= w_winner;
                        r_ra    <= w_winner ? ra1 : ra0;
                        r_rb    <= w_winner ? rb1 : rb0;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_v     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_v    <= 1'b0;
                        r_last <= r_owner;
                    end else begin
                        r_acc <= mac_sum;
                        r_v   <= r_v | mac_ovf;
                        r_idx <= r_idx + IW'(1);
                        if (w_last_elem) r_result <= mac_sum;
                    end
                end
                S_DONE:  r_last <= r_owner;
                default: ;
            endcase
        end
    end

    assign vrf_elem = r_idx;
    assign mac_a    = vrf_data_a;
    assign mac_b    = vrf_data_b;
    assign mac_acc  = r_acc;
    assign result   = r_result;
    assign V        = r_v;

endmodule

// File: tb/tb_vdot_sched.sv
// Bench for vdot_sched: behavioural VRF and FP16 MAC, directed vector table,
// multi-cycle corner sequences and randomized jobs against a reference model.
module tb_vdot_sched;

    logic        Clk;
    logic        Reset;
    logic [1:0]  req;
    logic [2:0]  ra0, rb0, ra1, rb1;
    logic [1:0]  grant, done;
    logic        busy;
    logic [2:0]  vrf_addr_a, vrf_addr_b;
    logic [3:0]  vrf_elem;
    logic [15:0] vrf_data_a, vrf_data_b;
    logic [15:0] mac_a, mac_b, mac_acc, mac_sum;
    logic        mac_ovf;
    logic [15:0] result;
    logic        V;

    logic [15:0] vrf [8][16];

    int n_cmp = 0;
    int n_err = 0;

    vdot_sched dut (
        .Clk(Clk), .Reset(Reset), .req(req),
        .ra0(ra0), .rb0(rb0), .ra1(ra1), .rb1(rb1),
        .grant(grant), .done(done), .busy(busy),
        .vrf_addr_a(vrf_addr_a), .vrf_addr_b(vrf_addr_b), .vrf_elem(vrf_elem),
        .vrf_data_a(vrf_data_a), .vrf_data_b(vrf_data_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .mac_sum(mac_sum), .mac_ovf(mac_ovf),
        .result(result), .V(V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Half-precision helpers: subnormals flush to zero, infinity saturates.
    function automatic real fp16_to_real(input logic [15:0] h);
        int  e;
        real r;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        if (e == 31) r = 1.0e9;
        else begin
            r = 1.0 + real'(int'(h[9:0])) / 1024.0;
            for (int k = 15; k < e; k++) r = r * 2.0;
            for (int k = e; k < 15; k++) r = r / 2.0;
        end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [16:0] real_to_fp16(input real x);
        real  a;
        int   e, m;
        logic s;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a == 0.0) return 17'h0;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -40) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        if (m == 1024) begin m = 0; e++; end
        if (e + 15 >= 31) return {1'b1, s, 5'h1F, 10'h0};
        if (e + 15 <= 0) return 17'h0;
        return {1'b0, s, 5'(e + 15), 10'(m)};
    endfunction

    function automatic logic [16:0] mac_fn(input logic [15:0] a, b, acc);
        logic [16:0] p, s;
        p = real_to_fp16(fp16_to_real(a) * fp16_to_real(b));
        s = real_to_fp16(fp16_to_real(p[15:0]) + fp16_to_real(acc));
        return {p[16] | s[16], s[15:0]};
    endfunction

    assign vrf_data_a = vrf[vrf_addr_a][vrf_elem];
    assign vrf_data_b = vrf[vrf_addr_b][vrf_elem];
    assign {mac_ovf, mac_sum} = mac_fn(mac_a, mac_b, mac_acc);

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int r, input logic [15:0] v);
        for (int i = 0; i < 16; i++) vrf[r][i] = v;
    endtask

    // Starts in IDLE with req applied; returns in the done cycle (or on timeout).
    task automatic run_job(input logic [1:0] exp_g, input string tag, input bit scramble);
        int n, g_err, e_err;
        n = 0; g_err = 0; e_err = 0;
        while (done == 2'b00 && n < 40) begin
            tick;
            n++;
            if (scramble && n == 1) begin
                ra0 = 3'($urandom); rb0 = 3'($urandom);
                ra1 = 3'($urandom); rb1 = 3'($urandom);
            end
            if (grant !== exp_g) g_err++;
            if (done == 2'b00 && vrf_elem !== 4'(n - 1)) e_err++;
        end
        check({tag, "_latency"}, n, 17);
        check({tag, "_grant"}, g_err, 0);
        check({tag, "_elem"}, e_err, 0);
        check({tag, "_done"}, done, exp_g);
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] exp_res;
        logic        exp_v;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          m_last;
        int          idx_bound;
        int          v_err;
        logic [1:0]  p;
        logic        w;
        logic [2:0]  a_w, b_w;
        logic [15:0] m_acc;
        logic        m_v;
        logic [16:0] r;

        tbl[0] = '{16'h3C00, 16'h3C00, 16'h4C00, 1'b0};  // 1.0*1.0 x16 = 16.0
        tbl[1] = '{16'h4000, 16'h3800, 16'h4C00, 1'b0};  // 2.0*0.5 x16 = 16.0
        tbl[2] = '{16'h3E00, 16'h4000, 16'h5200, 1'b0};  // 1.5*2.0 x16 = 48.0
        tbl[3] = '{16'h3800, 16'h3800, 16'h4400, 1'b0};  // 0.25 x16 = 4.0
        tbl[4] = '{16'hBC00, 16'h3C00, 16'hCC00, 1'b0};  // -1.0 x16 = -16.0
        tbl[5] = '{16'h5C00, 16'h5C00, 16'h7C00, 1'b1};  // 256*256 overflows

        for (int rr = 0; rr < 8; rr++) fill(rr, 16'h0000);
        Reset = 1'b1; req = 2'b00;
        ra0 = 3'd1; rb0 = 3'd2; ra1 = 3'd3; rb1 = 3'd4;
        tick; tick;
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 16'h0);
        check("rst_v", V, 1'b0);
        check("rst_addr", {vrf_addr_a, vrf_addr_b}, 6'h0);
        check("rst_elem", vrf_elem, 4'h0);
        Reset = 1'b0;
        tick;

        // Directed single jobs from requester 0 on registers 1 and 2.
        for (int t = 0; t < 6; t++) begin
            fill(1, tbl[t].va);
            fill(2, tbl[t].vb);
            ra0 = 3'd1; rb0 = 3'd2;
            req = 2'b01;
            run_job(2'b01, $sformatf("tbl%0d", t), 1'b0);
            check($sformatf("tbl%0d_result", t), result, tbl[t].exp_res);
            check($sformatf("tbl%0d_v", t), V, tbl[t].exp_v);
            req = 2'b00;
            tick;
            check($sformatf("tbl%0d_pulse", t), {done, grant, busy}, 5'b0);
        end

        // Tie after reset: requester 0 first, then strict alternation.
        fill(1, 16'h3C00); fill(2, 16'h3C00);
        fill(3, 16'h4000); fill(4, 16'h3800);
        ra0 = 3'd1; rb0 = 3'd2; ra1 = 3'd3; rb1 = 3'd4;
        Reset = 1'b1; tick; Reset = 1'b0;
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            run_job((j % 2 == 0) ? 2'b01 : 2'b10, $sformatf("fair%0d", j), 1'b0);
            check($sformatf("fair%0d_result", j), result, 16'h4C00);
            tick;
            check($sformatf("fair%0d_gap", j), {grant, busy}, 3'b0);
        end
        req = 2'b00;
        tick;

        // Overflow on element 0 only; V must be sticky through done.
        fill(5, 16'h0000); fill(6, 16'h0000);
        vrf[5][0] = 16'h7800; vrf[6][0] = 16'h7800;
        ra0 = 3'd5; rb0 = 3'd6; req = 2'b01;
        tick;
        check("ovf_elem0_v", V, 1'b0);
        v_err = 0; idx_bound = 0;
        while (done == 2'b00 && idx_bound < 30) begin
            tick; idx_bound++;
            if (V !== 1'b1) v_err++;
        end
        check("ovf_sticky", v_err, 0);
        check("ovf_done", done, 2'b01);
        check("ovf_v_at_done", V, 1'b1);
        req = 2'b00; tick;
        ra0 = 3'd1; rb0 = 3'd2; req = 2'b01;
        run_job(2'b01, "post_ovf", 1'b0);
        check("post_ovf_v", V, 1'b0);
        check("post_ovf_result", result, 16'h4C00);
        req = 2'b00; tick;

        // Abort by the owner at element 5.
        req = 2'b01; idx_bound = 0;
        tick;
        while (!(busy && vrf_elem == 4'd5) && idx_bound < 30) begin tick; idx_bound++; end
        check("abort_reach_elem5", vrf_elem, 4'd5);
        req = 2'b00;
        tick;
        check("abort_idle", {grant, busy, done}, 5'b0);
        check("abort_result_held", result, 16'h4C00);
        check("abort_v", V, 1'b0);
        tick;
        check("abort_no_done", done, 2'b00);
        ra1 = 3'd1; rb1 = 3'd2; req = 2'b11;
        tick;
        check("abort_last_is_owner", grant, 2'b10);

        // Reset in the middle of requester 1's job.
        idx_bound = 0;
        while (vrf_elem != 4'd8 && idx_bound < 30) begin tick; idx_bound++; end
        check("rst_mid_reach_elem8", vrf_elem, 4'd8);
        Reset = 1'b1;
        tick;
        check("rst_mid_state", {grant, busy, done}, 5'b0);
        check("rst_mid_result", result, 16'h0);
        check("rst_mid_v", V, 1'b0);
        Reset = 1'b0;
        tick;
        check("rst_mid_first_grant", grant, 2'b01);
        req = 2'b00;
        tick;
        check("rst_mid_abort_idle", busy, 1'b0);
        m_last = 0;

        // Randomized jobs against the reference model.
        for (int rr = 0; rr < 8; rr++)
            for (int i = 0; i < 16; i++)
                vrf[rr][i] = {1'($urandom), 5'(12 + $urandom_range(0, 5)), 10'($urandom)};
        for (int j = 0; j < 10; j++) begin
            p = 2'($urandom_range(1, 3));
            w = (p == 2'b11) ? ~m_last[0] : p[1];
            ra0 = 3'($urandom); rb0 = 3'($urandom);
            ra1 = 3'($urandom); rb1 = 3'($urandom);
            a_w = w ? ra1 : ra0;
            b_w = w ? rb1 : rb0;
            m_acc = 16'h0; m_v = 1'b0;
            for (int i = 0; i < 16; i++) begin
                r = mac_fn(vrf[a_w][i], vrf[b_w][i], m_acc);
                m_acc = r[15:0];
                m_v   = m_v | r[16];
            end
            req = p;
            run_job(w ? 2'b10 : 2'b01, $sformatf("rand%0d", j), 1'b1);
            check($sformatf("rand%0d_result", j), result, m_acc);
            check($sformatf("rand%0d_v", j), V, m_v);
            m_last = int'(w);
            req = 2'b00;
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
